minicpu_sequencer: RTL

Program sequencer that sits in front of the MiniCPU datapath and drives its 12-bit instruction port. Software preloads a small instruction store; on `start` the block issues stored words to the CPU one at a time, holds each word until the CPU outputs have settled, captures `out`/`overflow`, and reports completion with a status code. It replaces hand-driven instruction streams with a repeatable, self-timed run.

---
 rtl/minicpu_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/minicpu_sequencer.sv
// Program sequencer for the MiniCPU: issues preloaded instruction words one at a time,
// holds each word until the CPU outputs settle, and reports the run outcome.
module minicpu_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int CPU_LAT = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [11:0]   prog_data,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          halt_on_ovf,
    input  logic          abort,
    output logic [11:0]   cpu_in,
    input  logic [7:0]    cpu_out,
    input  logic          cpu_overflow,
    output logic          busy,
    output logic          done,
    output logic [1:0]    status,
    output logic [AW-1:0] pc,
    output logic [7:0]    result,
    output logic          ovf_sticky
);

    localparam int CW = 3;
    localparam logic [CW-1:0] CNT_MAX = CW'(CPU_LAT);
    localparam logic [3:0]    OP_HALT = 4'hF;

    localparam logic [1:0] ST_COMPLETE = 2'b00;
    localparam logic [1:0] ST_HALTED   = 2'b01;
    localparam logic [1:0] ST_OVFSTOP  = 2'b10;
    localparam logic [1:0] ST_ABORTED  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [11:0]     cpuIn_q, cpuIn_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      status_q, status_d;
    logic [7:0]      result_q, result_d;
    logic            ovfSticky_q, ovfSticky_d;

    logic [11:0]     mem_q [DEPTH];

    logic [AW-1:0]   pcNext;
    logic [AW:0]     lenMinus1;
    logic            lastWord;
    logic            nextIsHalt;

    // The store is deliberately left out of reset so a program survives a reset pulse.
    always_ff @(posedge clock) begin
        if (prog_we && state_q == S_IDLE) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign pcNext     = pc_q + AW'(1);
    assign lenMinus1  = len - (AW+1)'(1);
    assign lastWord   = ({1'b0, pc_q} == lenMinus1);
    assign nextIsHalt = (mem_q[pcNext][11:8] == OP_HALT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cpuIn_q     <= 12'h000;
            pc_q        <= '0;
            cnt_q       <= '0;
            status_q    <= ST_COMPLETE;
            result_q    <= 8'h00;
            ovfSticky_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpuIn_q     <= cpuIn_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            status_q    <= status_d;
            result_q    <= result_d;
            ovfSticky_q <= ovfSticky_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cpuIn_d     = cpuIn_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        status_d    = status_q;
        result_d    = result_q;
        ovfSticky_d = ovfSticky_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    status_d    = ST_COMPLETE;
                    result_d    = 8'h00;
                    ovfSticky_d = 1'b0;
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else if (mem_q[0][11:8] == OP_HALT) begin
                        state_d  = S_DONE;
                        status_d = ST_HALTED;
                    end else begin
                        state_d = S_ISSUE;
                        cpuIn_d = mem_q[0];
                        pc_d    = '0;
                        cnt_d   = '0;
                    end
                end
            end

            S_ISSUE: begin
                // Abort wins over everything and skips the capture on its edge.
                if (abort) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORTED;
                end else if (cnt_q == CNT_MAX) begin
                    result_d    = cpu_out;
                    ovfSticky_d = ovfSticky_q | cpu_overflow;
                    if (halt_on_ovf && cpu_overflow) begin
                        state_d  = S_DONE;
                        status_d = ST_OVFSTOP;
                    end else if (lastWord) begin
                        state_d  = S_DONE;
                        status_d = ST_COMPLETE;
                    end else if (nextIsHalt) begin
                        state_d  = S_DONE;
                        status_d = ST_HALTED;
                    end else begin
                        pc_d    = pcNext;
                        cpuIn_d = mem_q[pcNext];
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cpu_in     = cpuIn_q;
    assign pc         = pc_q;
    assign status     = status_q;
    assign result     = result_q;
    assign ovf_sticky = ovfSticky_q;
    assign busy       = (state_q == S_ISSUE);
    assign done       = (state_q == S_DONE);

endmodule
